llc_input_arbiter: RTL and testbench
====================================

Name: llc_input_arbiter

Overview:
- Front-end scheduler for the LLC pipeline. Each cycle it chooses at most one of four input channels: rsp_in, rst_tb, req_in and dma_req_in.
- It blocks requests whose set already has a transaction in flight. Each granted transaction gets an in-flight ID, and the grant is presented to the pipeline through a one-entry registered issue slot.
- The ID is returned on retire from UPDATE. This replaces the decode-only serialisation so that the READ_SET/LOOKUP/PROCESS stages can overlap.

Parameters:
- SET_BITS, `LLC_SET_BITS: width of the set index.
- NUM_INFLIGHT, 4: number of in-flight tracking entries, 2..8.
- ID_BITS, $clog2(NUM_INFLIGHT): width of the in-flight ID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- rsp_valid  in  1  rsp_in channel has a message.
- rsp_set  in  SET_BITS  set of the rsp_in message.
- rsp_ready  out  1  rsp_in message accepted this cycle.
- rst_tb_valid / rst_tb_set / rst_tb_ready  in / in / out  1 / SET_BITS / 1  same handshake for the reset/flush channel.
- req_valid / req_set / req_ready  in / in / out  1 / SET_BITS / 1  same handshake for the CPU request channel.
- dma_valid / dma_set / dma_ready  in / in / out  1 / SET_BITS / 1  same handshake for the DMA request channel.
- req_stall  in  1  block req_in only (recall or req pending).
- flush_stall  in  1  when high, only rsp and rst_tb may be granted.
- rst_stall  in  1  same effect as flush_stall.
- issue_valid  out  1  issue slot holds a transaction.
- issue_src  out  2  source of the held transaction: 0 rsp, 1 rst_tb, 2 req, 3 dma.
- issue_set  out  SET_BITS  set of the held transaction.
- issue_id  out  ID_BITS  in-flight ID allocated to it.
- issue_ready  in  1  pipeline accepts the issue slot.
- retire_valid  in  1  a transaction completed in UPDATE.
- retire_id  in  ID_BITS  ID of the completed transaction.
- inflight_full  out  1  all tracking entries are busy.
- err_retire  out  1  sticky: a retire targeted a free entry.

Behaviour:
- Reset (rst==0 at posedge):
  - all entries free, issue_valid=0, issue_src/set/id=0;
  - err_retire=0, round-robin pointer points at req;
  - all *_ready outputs are 0 while rst is low.
- Slot free: slot_free = !issue_valid | issue_ready. A grant may occur only when slot_free && !inflight_full.
- Eligibility:
  - rsp: rsp_valid. Set-conflict check is skipped, because responses resolve in-flight recalls; this avoids deadlock.
  - rst_tb: rst_tb_valid. Conflict check is skipped.
  - req: req_valid && !req_stall && !flush_stall && !rst_stall && no busy entry with set==req_set.
  - dma: dma_valid && !flush_stall && !rst_stall && no busy entry with set==dma_set.
- Priority: rsp > rst_tb > {req, dma}.
  - req and dma share one round-robin pointer. The pointer flips to the other source after every req or dma grant.
  - If only one of req and dma is eligible, it is granted regardless of the pointer.
- Grant cycle:
  - exactly one *_ready is high, combinational from this cycle's valids and state;
  - at posedge: issue_valid=1; issue_src/set are loaded; issue_id = lowest-index free entry; that entry is marked busy with the granted set.
- Hold: issue outputs stay stable while issue_valid && !issue_ready. Issue then grant in the same cycle is allowed (back-to-back, one grant per cycle).
- Issue without new grant: issue_valid clears.
- Latency: a grant presents on issue_* in the next cycle. Maximum throughput is 1 per cycle.
- Retire: retire_valid frees entry retire_id at posedge.
  - If the entry is already free: no state change; err_retire is set and stays set until reset.
  - Retire and grant in the same cycle: the retired entry is free for allocation in that same cycle's combinational conflict and full checks. Retire state is applied before allocation.
- Conflict comparison uses busy entries after the same-cycle retire. The entry currently being allocated is not included in its own cycle's check.
- inflight_full = all entries busy, computed from registered state.
- A held slot does not block retires. Stall inputs do not affect an already-loaded slot.
- Reset mid-operation discards the held slot and all busy entries without retiring them.

Decomposition:
- Shared package (cache_consts/cache_types): SET_BITS default, the llc_src_t encoding (RSP=0, RST_TB=1, REQ=2, DMA=3) and the NUM_INFLIGHT constant.
- Sub-module llc_inflight_table: busy and set storage, lowest-free allocator, per-requester conflict compare for two sets, retire logic and err flag.
- The arbiter top holds the priority and round-robin logic and the issue register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all valids high -> all *_ready=0, issue_valid=0, err_retire=0; after release, the first grant is rsp.
- Priority and round-robin: rsp and rst_tb idle; req and dma valid continuously with sets 1 and 2; issue_ready=1; retire each ID 1 cycle after issue -> grants alternate req, dma, req, dma.
- Set conflict: req_set=5 granted with ID 0 and not retired; dma_set=5 valid -> dma_ready=0. Retire ID 0 -> dma granted that same cycle with issue_id=0.
- Full and backpressure: 4 req grants to sets 0..3 with no retire -> inflight_full=1 and rsp_ready=0. With issue_ready=0, issue_* stay stable for 5 cycles.
- Stalls: flush_stall=1 with req, dma and rst_tb valid -> only rst_tb granted; req_stall=1 blocks req while dma is still granted.
- Bad retire: retire_id=3 while entry 3 is free -> err_retire=1, sticky until reset; busy entries are unchanged.

Source files
------------

// File: rtl/llc_input_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// llc_input_arbiter_pkg : shared constants and source encoding, LLC input arbiter
// Revision: 1.0
// ============================================================================
package llc_input_arbiter_pkg;

  localparam int LLC_SET_BITS     = 8;
  localparam int LLC_NUM_INFLIGHT = 4;

  typedef enum logic [1:0] {
    SRC_RSP    = 2'd0,
    SRC_RST_TB = 2'd1,
    SRC_REQ    = 2'd2,
    SRC_DMA    = 2'd3
  } llc_src_t;

endpackage
`default_nettype wire

// File: rtl/llc_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// llc_input_arbiter_if : input channels, issue slot and retire bus of the arbiter
// Revision: 1.0
// ============================================================================
interface llc_input_arbiter_if
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS = LLC_SET_BITS,
  parameter int ID_BITS  = $clog2(LLC_NUM_INFLIGHT)
);
  logic                rsp_valid;
  logic [SET_BITS-1:0] rsp_set;
  logic                rsp_ready;
  logic                rst_tb_valid;
  logic [SET_BITS-1:0] rst_tb_set;
  logic                rst_tb_ready;
  logic                req_valid;
  logic [SET_BITS-1:0] req_set;
  logic                req_ready;
  logic                dma_valid;
  logic [SET_BITS-1:0] dma_set;
  logic                dma_ready;
  logic                req_stall;
  logic                flush_stall;
  logic                rst_stall;
  logic                issue_valid;
  llc_src_t            issue_src;
  logic [SET_BITS-1:0] issue_set;
  logic [ID_BITS-1:0]  issue_id;
  logic                issue_ready;
  logic                retire_valid;
  logic [ID_BITS-1:0]  retire_id;
  logic                inflight_full;
  logic                err_retire;

  modport master (
    output rsp_valid, rsp_set, rst_tb_valid, rst_tb_set,
           req_valid, req_set, dma_valid, dma_set,
           req_stall, flush_stall, rst_stall,
           issue_ready, retire_valid, retire_id,
    input  rsp_ready, rst_tb_ready, req_ready, dma_ready,
           issue_valid, issue_src, issue_set, issue_id,
           inflight_full, err_retire
  );

  modport slave (
    input  rsp_valid, rsp_set, rst_tb_valid, rst_tb_set,
           req_valid, req_set, dma_valid, dma_set,
           req_stall, flush_stall, rst_stall,
           issue_ready, retire_valid, retire_id,
    output rsp_ready, rst_tb_ready, req_ready, dma_ready,
           issue_valid, issue_src, issue_set, issue_id,
           inflight_full, err_retire
  );

endinterface
`default_nettype wire

// File: rtl/llc_input_arbiter_inflight_table.sv
`default_nettype none
// ============================================================================
// llc_inflight_table : busy/set tracking, lowest-free allocation, conflicts, retire
// Revision: 1.0
// ============================================================================
module llc_inflight_table
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS     = LLC_SET_BITS,
  parameter int NUM_INFLIGHT = LLC_NUM_INFLIGHT,
  parameter int ID_BITS      = $clog2(NUM_INFLIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                retire_valid_i,
  input  logic [ID_BITS-1:0]  retire_id_i,
  input  logic                alloc_i,
  input  logic [SET_BITS-1:0] alloc_set_i,
  input  logic [SET_BITS-1:0] req_set_i,
  input  logic [SET_BITS-1:0] dma_set_i,
  output logic [ID_BITS-1:0]  alloc_id_o,
  output logic                req_conflict_o,
  output logic                dma_conflict_o,
  output logic                has_free_o,
  output logic                full_o,
  output logic                err_retire_o
);

  logic [NUM_INFLIGHT-1:0] busy_q;
  logic [NUM_INFLIGHT-1:0] busy_d;
  logic [SET_BITS-1:0]     set_q [NUM_INFLIGHT];
  logic                    err_q;
  logic [NUM_INFLIGHT-1:0] retire_hit;
  logic [NUM_INFLIGHT-1:0] busy_eff;
  logic [NUM_INFLIGHT-1:0] alloc_oh;
  logic                    bad_retire;

  // Retire is applied first so a freed entry is visible to this cycle's checks.
  always_comb begin
    retire_hit = '0;
    for (int i = 0; i < NUM_INFLIGHT; i++) begin
      retire_hit[i] = retire_valid_i && (retire_id_i == ID_BITS'(i));
    end
  end

  assign busy_eff   = busy_q & ~retire_hit;
  assign bad_retire = retire_valid_i && !(|(retire_hit & busy_q));

  always_comb begin
    logic found;
    found      = 1'b0;
    alloc_oh   = '0;
    alloc_id_o = '0;
    for (int i = 0; i < NUM_INFLIGHT; i++) begin
      if (!busy_eff[i] && !found) begin
        found       = 1'b1;
        alloc_oh[i] = 1'b1;
        alloc_id_o  = ID_BITS'(i);
      end
    end
  end

  always_comb begin
    req_conflict_o = 1'b0;
    dma_conflict_o = 1'b0;
    for (int i = 0; i < NUM_INFLIGHT; i++) begin
      if (busy_eff[i] && (set_q[i] == req_set_i)) req_conflict_o = 1'b1;
      if (busy_eff[i] && (set_q[i] == dma_set_i)) dma_conflict_o = 1'b1;
    end
  end

  assign busy_d       = busy_eff | (alloc_i ? alloc_oh : '0);
  assign has_free_o   = ~&busy_eff;
  assign full_o       = &busy_q;
  assign err_retire_o = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_INFLIGHT; i++) set_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (bad_retire) err_q <= 1'b1;
      for (int i = 0; i < NUM_INFLIGHT; i++) begin
        if (alloc_i && alloc_oh[i]) set_q[i] <= alloc_set_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/llc_input_arbiter.sv
`default_nettype none
// ============================================================================
// llc_input_arbiter : four-channel LLC front-end scheduler with in-flight set tracking
// Revision: 1.0
// ============================================================================
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int SET_BITS     = LLC_SET_BITS,
  parameter int NUM_INFLIGHT = LLC_NUM_INFLIGHT,
  parameter int ID_BITS      = $clog2(NUM_INFLIGHT)
) (
  input  logic         clk,
  input  logic         rst,
  llc_input_arbiter_if.slave bus
);

  logic                issue_valid_q, issue_valid_d;
  llc_src_t            issue_src_q,   issue_src_d;
  logic [SET_BITS-1:0] issue_set_q,   issue_set_d;
  logic [ID_BITS-1:0]  issue_id_q,    issue_id_d;
  logic                rr_dma_q,      rr_dma_d;

  logic                grant;
  llc_src_t            grant_src;
  logic [SET_BITS-1:0] grant_set;
  logic [ID_BITS-1:0]  alloc_id;
  logic                req_conflict;
  logic                dma_conflict;
  logic                has_free;
  logic                slot_free;
  logic                can_grant;
  logic                req_elig;
  logic                dma_elig;

  llc_inflight_table #(
    .SET_BITS    (SET_BITS),
    .NUM_INFLIGHT(NUM_INFLIGHT),
    .ID_BITS     (ID_BITS)
  ) u_table (
    .clk           (clk),
    .rst           (rst),
    .retire_valid_i(bus.retire_valid),
    .retire_id_i   (bus.retire_id),
    .alloc_i       (grant),
    .alloc_set_i   (grant_set),
    .req_set_i     (bus.req_set),
    .dma_set_i     (bus.dma_set),
    .alloc_id_o    (alloc_id),
    .req_conflict_o(req_conflict),
    .dma_conflict_o(dma_conflict),
    .has_free_o    (has_free),
    .full_o        (bus.inflight_full),
    .err_retire_o  (bus.err_retire)
  );

  // rst gates grants so no ready can rise while reset is held.
  assign slot_free = !issue_valid_q || bus.issue_ready;
  assign can_grant = rst && slot_free && has_free;
  assign req_elig  = bus.req_valid && !bus.req_stall && !bus.flush_stall
                   && !bus.rst_stall && !req_conflict;
  assign dma_elig  = bus.dma_valid && !bus.flush_stall && !bus.rst_stall
                   && !dma_conflict;

  // rsp and rst_tb bypass the conflict check: responses resolve pending recalls.
  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_RSP;
    grant_set = bus.rsp_set;
    if (can_grant) begin
      if (bus.rsp_valid) begin
        grant     = 1'b1;
        grant_src = SRC_RSP;
        grant_set = bus.rsp_set;
      end else if (bus.rst_tb_valid) begin
        grant     = 1'b1;
        grant_src = SRC_RST_TB;
        grant_set = bus.rst_tb_set;
      end else if (req_elig && (!dma_elig || !rr_dma_q)) begin
        grant     = 1'b1;
        grant_src = SRC_REQ;
        grant_set = bus.req_set;
      end else if (dma_elig) begin
        grant     = 1'b1;
        grant_src = SRC_DMA;
        grant_set = bus.dma_set;
      end
    end
  end

  assign bus.rsp_ready    = grant && (grant_src == SRC_RSP);
  assign bus.rst_tb_ready = grant && (grant_src == SRC_RST_TB);
  assign bus.req_ready    = grant && (grant_src == SRC_REQ);
  assign bus.dma_ready    = grant && (grant_src == SRC_DMA);

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_src_d   = issue_src_q;
    issue_set_d   = issue_set_q;
    issue_id_d    = issue_id_q;
    rr_dma_d      = rr_dma_q;
    if (grant) begin
      issue_valid_d = 1'b1;
      issue_src_d   = grant_src;
      issue_set_d   = grant_set;
      issue_id_d    = alloc_id;
      if (grant_src == SRC_REQ) rr_dma_d = 1'b1;
      if (grant_src == SRC_DMA) rr_dma_d = 1'b0;
    end else if (bus.issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_src_q   <= SRC_RSP;
      issue_set_q   <= '0;
      issue_id_q    <= '0;
      rr_dma_q      <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_src_q   <= issue_src_d;
      issue_set_q   <= issue_set_d;
      issue_id_q    <= issue_id_d;
      rr_dma_q      <= rr_dma_d;
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_src   = issue_src_q;
  assign bus.issue_set   = issue_set_q;
  assign bus.issue_id    = issue_id_q;

endmodule
`default_nettype wire

// File: tb/tb_llc_input_arbiter.sv
`default_nettype none
// ============================================================================
// tb_llc_input_arbiter : directed self-checking bench for llc_input_arbiter
// Revision: 1.0
// ============================================================================
module tb_llc_input_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  llc_input_arbiter_if #(.SET_BITS(8), .ID_BITS(2)) bus ();

  llc_input_arbiter #(
    .SET_BITS    (8),
    .NUM_INFLIGHT(4),
    .ID_BITS     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue slot packed as {valid, src, set, id}.
  task automatic chk_iss(input string tag, input logic v, input logic [1:0] src,
                         input logic [7:0] set, input logic [1:0] id);
    chk(tag, {19'd0, bus.issue_valid, bus.issue_src, bus.issue_set, bus.issue_id},
             {19'd0, v, src, set, id});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b0;
    bus.rsp_valid    = 1'b1; bus.rsp_set    = 8'd9;
    bus.rst_tb_valid = 1'b1; bus.rst_tb_set = 8'd3;
    bus.req_valid    = 1'b1; bus.req_set    = 8'd1;
    bus.dma_valid    = 1'b1; bus.dma_set    = 8'd2;
    bus.req_stall    = 1'b0;
    bus.flush_stall  = 1'b0;
    bus.rst_stall    = 1'b0;
    bus.issue_ready  = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_id    = 2'd0;

    tick(); tick();
    chk("reset_rsp_ready",    bus.rsp_ready,    0);
    chk("reset_rst_tb_ready", bus.rst_tb_ready, 0);
    chk("reset_req_ready",    bus.req_ready,    0);
    chk("reset_dma_ready",    bus.dma_ready,    0);
    chk_iss("reset_issue", 0, 0, 0, 0);
    chk("reset_err",          bus.err_retire,   0);
    chk("reset_full",         bus.inflight_full, 0);

    rst = 1'b1; #1;
    chk("first_rsp_ready",    bus.rsp_ready,    1);
    chk("first_rst_tb_ready", bus.rst_tb_ready, 0);
    tick();
    chk_iss("first_grant_rsp", 1, 0, 9, 0);

    // req/dma alternate, retiring ID 0 each cycle so it is reused
    bus.rsp_valid = 1'b0; bus.rst_tb_valid = 1'b0;
    bus.issue_ready = 1'b1;
    bus.retire_valid = 1'b1; bus.retire_id = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_req_ready", bus.req_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_dma_ready", bus.dma_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      chk_iss("rr_grant", 1, (k % 2 == 0) ? 2'd2 : 2'd3, (k % 2 == 0) ? 8'd1 : 8'd2, 0);
    end
    bus.req_valid = 1'b0; bus.dma_valid = 1'b0;
    tick();
    chk("drain_issue_valid", bus.issue_valid, 0);
    chk("drain_full", bus.inflight_full, 0);
    bus.retire_valid = 1'b0;

    // set conflict
    bus.req_valid = 1'b1; bus.req_set = 8'd5; #1;
    chk("conf_req_ready", bus.req_ready, 1);
    tick();
    chk_iss("conf_req_grant", 1, 2, 5, 0);
    bus.req_valid = 1'b0; bus.dma_valid = 1'b1; bus.dma_set = 8'd5; #1;
    chk("conf_dma_blocked", bus.dma_ready, 0);
    tick();
    chk("conf_dma_still_blocked", bus.dma_ready, 0);
    chk("conf_issue_cleared", bus.issue_valid, 0);
    bus.retire_valid = 1'b1; bus.retire_id = 2'd0; #1;
    chk("conf_dma_after_retire", bus.dma_ready, 1);
    tick();
    chk_iss("conf_dma_grant", 1, 3, 5, 0);
    bus.dma_valid = 1'b0;
    tick();
    bus.retire_valid = 1'b0;

    // fill all entries, then backpressure
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_set = 8'(k);
      tick();
      chk_iss("full_grant", 1, 2, 8'(k), 2'(k));
    end
    chk("full_flag", bus.inflight_full, 1);
    bus.req_valid = 1'b0; bus.issue_ready = 1'b0;
    bus.rsp_valid = 1'b1; bus.rsp_set = 8'd7; #1;
    chk("full_rsp_blocked", bus.rsp_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_iss("hold_stable", 1, 2, 3, 3);
    end
    bus.issue_ready = 1'b1; bus.retire_valid = 1'b1; bus.retire_id = 2'd0; #1;
    chk("retire_unblocks_rsp", bus.rsp_ready, 1);
    tick();
    chk_iss("rsp_reuses_id0", 1, 0, 7, 0);
    bus.rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.retire_id = 2'(k);
      tick();
    end
    bus.retire_valid = 1'b0;
    chk("empty_full", bus.inflight_full, 0);
    chk("empty_issue_valid", bus.issue_valid, 0);
    chk("empty_err", bus.err_retire, 0);

    // stalls
    bus.flush_stall = 1'b1;
    bus.req_valid = 1'b1;    bus.req_set    = 8'd10;
    bus.dma_valid = 1'b1;    bus.dma_set    = 8'd11;
    bus.rst_tb_valid = 1'b1; bus.rst_tb_set = 8'd12; #1;
    chk("flush_rst_tb_ready", bus.rst_tb_ready, 1);
    chk("flush_req_ready",    bus.req_ready,    0);
    chk("flush_dma_ready",    bus.dma_ready,    0);
    tick();
    chk_iss("flush_grant", 1, 1, 12, 0);
    bus.rst_tb_valid = 1'b0; #1;
    chk("flush_only_req", bus.req_ready, 0);
    chk("flush_only_dma", bus.dma_ready, 0);
    bus.flush_stall = 1'b0; bus.rst_stall = 1'b1; #1;
    chk("rst_stall_dma", bus.dma_ready, 0);
    chk("rst_stall_req", bus.req_ready, 0);
    bus.rst_stall = 1'b0; bus.req_stall = 1'b1; #1;
    chk("req_stall_req", bus.req_ready, 0);
    chk("req_stall_dma", bus.dma_ready, 1);
    tick();
    chk_iss("req_stall_dma_grant", 1, 3, 11, 1);

    // bad retire: entry 0 stays busy (set 12), entry 3 is free
    bus.req_valid = 1'b0; bus.dma_valid = 1'b0; bus.req_stall = 1'b0;
    bus.retire_valid = 1'b1; bus.retire_id = 2'd1;
    tick();
    chk("good_retire_no_err", bus.err_retire, 0);
    bus.retire_id = 2'd3;
    tick();
    chk("bad_retire_err", bus.err_retire, 1);
    bus.retire_valid = 1'b0;
    bus.req_valid = 1'b1; bus.req_set = 8'd12; #1;
    chk("bad_retire_busy_kept", bus.req_ready, 0);
    bus.req_set = 8'd13; #1;
    chk("bad_retire_other_set", bus.req_ready, 1);
    tick();
    chk_iss("bad_retire_alloc_id1", 1, 2, 13, 1);
    bus.req_valid = 1'b0;
    tick(); tick();
    chk("err_sticky", bus.err_retire, 1);

    rst = 1'b0;
    tick();
    chk("rerst_err", bus.err_retire, 0);
    chk("rerst_issue_valid", bus.issue_valid, 0);
    chk("rerst_full", bus.inflight_full, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
